instruction_memory_loader: RTL and testbench

Word-organised instruction memory with a built-in debug loader.
- The debug unit streams program bytes over a valid/ready handshake. The block assembles them into instructions and writes them sequentially from word 0, stopping on a HALT word or a full memory.
- The pipeline fetch stage reads whole instructions by byte address with 1-cycle latency and gets alignment and range error flags.
- Sits between debug_unit (load side) and the IF stage (fetch side).

---
 rtl/instruction_memory_pkg.sv | 31 +++
 rtl/instr_word_ram.sv | 36 +++
 rtl/instruction_memory_loader.sv | 188 ++++++++++++++++++
 tb/tb_instruction_memory_loader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the instruction memory and its debug loader.
// Holds the loader state encoding and the compile-time helpers that derive
// the bytes-per-word figure and address widths from the block parameters.
package instruction_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int bytes_per_word(input int nb_instruction, input int nb_byte);
    return nb_instruction / nb_byte;
  endfunction

  // Number of byte-offset bits at the bottom of a fetch byte address.
  function automatic int byte_offset_width(input int nb_instruction, input int nb_byte);
    return clog2(bytes_per_word(nb_instruction, nb_byte));
  endfunction

endpackage

// File: rtl/instr_word_ram.sv
// Simple dual-port word RAM, single clock.
// Ports:
//   i_clock  - clock
//   wr_en    - write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  - write word address
//   wr_data  - write word
//   rd_en    - read strobe, rd_data updated on the rising edge when high
//   rd_addr  - read word address
//   rd_data  - registered read word; holds its value while rd_en is low
// The array starts out all zero so an unloaded word always reads as 0.
module instr_word_ram #(
  parameter int NB_DATA  = 32,
  parameter int DEPTH    = 64,
  parameter int NB_WADDR = 6
) (
  input  logic                i_clock,
  input  logic                wr_en,
  input  logic [NB_WADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0]  wr_data,
  input  logic                rd_en,
  input  logic [NB_WADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0]  rd_data
);

  logic [NB_DATA-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a built-in debug loader.
// The load side accepts program bytes over a valid/ready handshake, packs
// them into words and writes them from word 0 upward until a HALT word is
// written or the memory is full. The fetch side reads whole words by byte
// address with one cycle of latency and flags misaligned or out-of-range
// addresses.
// Ports:
//   i_clock, i_reset_n       - clock, async active-low reset
//   i_enable                 - global enable; low freezes every register
//   i_load_start             - begin a new program load
//   i_load_valid/i_load_byte - byte stream from the debug unit
//   o_load_ready             - loader is taking bytes (LOAD state)
//   o_load_done              - load finished, held until the next start
//   o_load_count             - words written by the current/last load
//   i_fetch_en/i_fetch_addr  - fetch request, byte address
//   o_instruction            - fetched word (0 when not valid)
//   o_fetch_valid            - o_instruction holds a real word
//   o_addr_misaligned        - last fetch address not word aligned
//   o_addr_out_of_range      - last fetch word index beyond the memory
module instruction_memory_loader
  import instruction_memory_pkg::*;
#(
  parameter int                        NB_BYTE        = 8,
  parameter int                        NB_INSTRUCTION = 32,
  parameter int                        MEMORY_DEPTH   = 64,
  parameter int                        NB_ADDR        = 32,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = 32'hFFFF_FFFF,
  parameter bit                        BIG_ENDIAN     = 1'b1
) (
  input  logic                                i_clock,
  input  logic                                i_reset_n,
  input  logic                                i_enable,
  input  logic                                i_load_start,
  input  logic                                i_load_valid,
  input  logic [NB_BYTE-1:0]                  i_load_byte,
  output logic                                o_load_ready,
  output logic                                o_load_done,
  output logic [clog2(MEMORY_DEPTH+1)-1:0]    o_load_count,
  input  logic                                i_fetch_en,
  input  logic [NB_ADDR-1:0]                  i_fetch_addr,
  output logic [NB_INSTRUCTION-1:0]           o_instruction,
  output logic                                o_fetch_valid,
  output logic                                o_addr_misaligned,
  output logic                                o_addr_out_of_range
);

  localparam int BPW     = bytes_per_word(NB_INSTRUCTION, NB_BYTE);
  localparam int OFF_W   = byte_offset_width(NB_INSTRUCTION, NB_BYTE);
  localparam int BC_W    = (OFF_W > 0) ? OFF_W : 1;
  localparam int WADDR_W = clog2(MEMORY_DEPTH);
  localparam int CNT_W   = clog2(MEMORY_DEPTH + 1);

  load_state_e               state_q;
  load_state_e               state_d;
  logic [BC_W-1:0]           byte_cnt_q;
  logic [WADDR_W-1:0]        word_ptr_q;
  logic [CNT_W-1:0]          load_count_q;
  logic [NB_INSTRUCTION-1:0] asm_q;
  logic [NB_INSTRUCTION-1:0] asm_d;
  int                        lane_sel;

  logic start_load;
  logic byte_accept;
  logic last_byte;
  logic word_complete;
  logic load_finished;

  logic [NB_ADDR-1:0]        fetch_word_index;
  logic                      fetch_active;
  logic                      fetch_misaligned;
  logic                      fetch_out_of_range;
  logic                      fetch_ok;
  logic                      fetch_valid_q;
  logic                      misaligned_q;
  logic                      out_of_range_q;
  logic [NB_INSTRUCTION-1:0] rd_data;

  // A start is honoured from IDLE or DONE only; mid-load starts are dropped.
  assign start_load    = i_enable & i_load_start & (state_q != LOAD);
  assign byte_accept   = i_enable & i_load_valid & (state_q == LOAD);
  assign last_byte     = (byte_cnt_q == BC_W'(BPW - 1));
  assign word_complete = byte_accept & last_byte;
  assign load_finished = word_complete &
                         ((asm_d == HALT_WORD) || (word_ptr_q == WADDR_W'(MEMORY_DEPTH - 1)));

  // Merge the incoming byte into its lane so the final byte of a word can be
  // written to memory on the same edge that accepts it.
  always_comb begin
    asm_d    = asm_q;
    lane_sel = BIG_ENDIAN ? (BPW - 1 - int'(byte_cnt_q)) : int'(byte_cnt_q);
    for (int lane = 0; lane < BPW; lane++) begin
      if (lane == lane_sel) begin
        asm_d[lane*NB_BYTE +: NB_BYTE] = i_load_byte;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else if (i_enable) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_load)    state_d = LOAD;
      LOAD:    if (load_finished) state_d = DONE;
      DONE:    if (start_load)    state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_load_ready = (state_q == LOAD);
    o_load_done  = (state_q == DONE);
  end

  // Reset discards any partially assembled word; memory is left untouched.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byte_cnt_q   <= '0;
      word_ptr_q   <= '0;
      load_count_q <= '0;
      asm_q        <= '0;
    end else if (start_load) begin
      byte_cnt_q   <= '0;
      word_ptr_q   <= '0;
      load_count_q <= '0;
      asm_q        <= '0;
    end else if (byte_accept) begin
      if (last_byte) begin
        byte_cnt_q   <= '0;
        asm_q        <= '0;
        word_ptr_q   <= word_ptr_q + WADDR_W'(1);
        load_count_q <= load_count_q + CNT_W'(1);
      end else begin
        byte_cnt_q <= byte_cnt_q + BC_W'(1);
        asm_q      <= asm_d;
      end
    end
  end

  assign o_load_count = load_count_q;

  // Range check is done on the full-width index so high addresses never
  // alias back into the array.
  assign fetch_word_index   = i_fetch_addr >> OFF_W;
  assign fetch_misaligned   = ((i_fetch_addr & NB_ADDR'(BPW - 1)) != '0);
  assign fetch_out_of_range = (fetch_word_index >= NB_ADDR'(MEMORY_DEPTH));
  // Fetch is blocked while loading so a read never meets a write.
  assign fetch_active       = i_fetch_en & (state_q != LOAD);
  assign fetch_ok           = fetch_active & ~fetch_misaligned & ~fetch_out_of_range;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_valid_q  <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else if (i_enable) begin
      fetch_valid_q  <= fetch_ok;
      misaligned_q   <= fetch_active & fetch_misaligned;
      out_of_range_q <= fetch_active & fetch_out_of_range;
    end
  end

  assign o_instruction       = fetch_valid_q ? rd_data : '0;
  assign o_fetch_valid       = fetch_valid_q;
  assign o_addr_misaligned   = misaligned_q;
  assign o_addr_out_of_range = out_of_range_q;

  instr_word_ram #(
    .NB_DATA  (NB_INSTRUCTION),
    .DEPTH    (MEMORY_DEPTH),
    .NB_WADDR (WADDR_W)
  ) u_ram (
    .i_clock (i_clock),
    .wr_en   (word_complete),
    .wr_addr (word_ptr_q),
    .wr_data (asm_d),
    .rd_en   (i_enable & fetch_ok),
    .rd_addr (fetch_word_index[WADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench for instruction_memory_loader. A big-endian instance
// is exercised through loads, fetches, resets and enable freezes; a second
// little-endian instance checks byte ordering. Expected words come from a
// byte-list model of the load rules kept in this file.
module tb_instruction_memory_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        i_clock;
  logic        i_reset_n;
  logic        i_enable;
  logic        i_load_start;
  logic        i_load_valid;
  logic [7:0]  i_load_byte;
  logic        o_load_ready;
  logic        o_load_done;
  logic [6:0]  o_load_count;
  logic        i_fetch_en;
  logic [31:0] i_fetch_addr;
  logic [31:0] o_instruction;
  logic        o_fetch_valid;
  logic        o_addr_misaligned;
  logic        o_addr_out_of_range;

  logic        le_load_start;
  logic        le_load_valid;
  logic [7:0]  le_load_byte;
  logic        le_load_ready;
  logic        le_load_done;
  logic [6:0]  le_load_count;
  logic        le_fetch_en;
  logic [31:0] le_fetch_addr;
  logic [31:0] le_instruction;
  logic        le_fetch_valid;
  logic        le_misaligned;
  logic        le_out_of_range;

  int n_checks;
  int n_errors;

  logic [31:0] model_mem [64];
  logic [7:0]  prog_q [$];
  logic [7:0]  tx_q [$];

  instruction_memory_loader dut (
    .i_clock             (i_clock),
    .i_reset_n           (i_reset_n),
    .i_enable            (i_enable),
    .i_load_start        (i_load_start),
    .i_load_valid        (i_load_valid),
    .i_load_byte         (i_load_byte),
    .o_load_ready        (o_load_ready),
    .o_load_done         (o_load_done),
    .o_load_count        (o_load_count),
    .i_fetch_en          (i_fetch_en),
    .i_fetch_addr        (i_fetch_addr),
    .o_instruction       (o_instruction),
    .o_fetch_valid       (o_fetch_valid),
    .o_addr_misaligned   (o_addr_misaligned),
    .o_addr_out_of_range (o_addr_out_of_range)
  );

  instruction_memory_loader #(.BIG_ENDIAN(1'b0)) dut_le (
    .i_clock             (i_clock),
    .i_reset_n           (i_reset_n),
    .i_enable            (i_enable),
    .i_load_start        (le_load_start),
    .i_load_valid        (le_load_valid),
    .i_load_byte         (le_load_byte),
    .o_load_ready        (le_load_ready),
    .o_load_done         (le_load_done),
    .o_load_count        (le_load_count),
    .i_fetch_en          (le_fetch_en),
    .i_fetch_addr        (le_fetch_addr),
    .o_instruction       (le_instruction),
    .o_fetch_valid       (le_fetch_valid),
    .o_addr_misaligned   (le_misaligned),
    .o_addr_out_of_range (le_out_of_range)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input bit big_endian);
    return big_endian ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic push_word(input logic [31:0] w);
    prog_q.push_back(w[31:24]);
    prog_q.push_back(w[23:16]);
    prog_q.push_back(w[15:8]);
    prog_q.push_back(w[7:0]);
  endtask

  // Reference: complete words from prog_q land at word 0 upward, stopping
  // after a HALT word or the 64th word.
  task automatic model_load(output int exp_count, output bit exp_done);
    logic [31:0] w;
    exp_count = 0;
    exp_done  = 1'b0;
    for (int k = 0; k < 64 && (4 * k + 3) < prog_q.size(); k++) begin
      w = pack_word(prog_q[4*k], prog_q[4*k+1], prog_q[4*k+2], prog_q[4*k+3], 1'b1);
      model_mem[k] = w;
      exp_count++;
      if (w == HALT || k == 63) begin
        exp_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_load();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
  endtask

  // Sends tx_q bytes while the loader is ready; accepted bytes are popped.
  task automatic stream(input bit gaps);
    int budget;
    bit will_accept;
    budget = 8 * tx_q.size() + 50;
    while (tx_q.size() > 0) begin
      if (!o_load_ready) break;
      if (budget == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL stream_timeout: bytes left %0d want 0", tx_q.size());
        break;
      end
      budget--;
      i_load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_load_byte  = tx_q[0];
      will_accept  = i_load_valid && o_load_ready && i_enable;
      step();
      if (will_accept) void'(tx_q.pop_front());
    end
    i_load_valid = 1'b0;
  endtask

  task automatic load_program(input bit gaps);
    tx_q = prog_q;
    start_load();
    stream(gaps);
  endtask

  task automatic fetch(input logic [31:0] addr);
    i_fetch_en   = 1'b1;
    i_fetch_addr = addr;
    step();
    i_fetch_en   = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    step();
    step();
    n_checks++; if (o_load_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_ready: got %0b want 0", o_load_ready); end
    n_checks++; if (o_load_done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_done: got %0b want 0", o_load_done); end
    n_checks++; if (o_load_count !== 7'd0) begin n_errors++; $display("[TB] FAIL reset_count: got %0d want 0", o_load_count); end
    n_checks++; if (o_fetch_valid !== 1'b0 || o_instruction !== 32'h0) begin n_errors++; $display("[TB] FAIL reset_fetch: got v=%0b %h want v=0 0", o_fetch_valid, o_instruction); end
    n_checks++; if (o_addr_misaligned !== 1'b0 || o_addr_out_of_range !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_flags: got %0b%0b want 00", o_addr_misaligned, o_addr_out_of_range); end
    #2 i_reset_n = 1'b1;
    step();
    fetch(32'd20);
    n_checks++; if (o_fetch_valid !== 1'b1 || o_instruction !== model_mem[5]) begin n_errors++; $display("[TB] FAIL zero_init_fetch: got v=%0b %h want v=1 %h", o_fetch_valid, o_instruction, model_mem[5]); end
  endtask

  task automatic test_directed_load();
    int ec; bit ed;
    prog_q = {8'h8C, 8'h01, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    model_load(ec, ed);
    load_program(1'b0);
    n_checks++; if (o_load_done !== ed) begin n_errors++; $display("[TB] FAIL directed_done: got %0b want %0b", o_load_done, ed); end
    n_checks++; if (o_load_count !== 7'(ec) || ec != 2) begin n_errors++; $display("[TB] FAIL directed_count: got %0d want 2 (model %0d)", o_load_count, ec); end
    n_checks++; if (o_load_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL directed_ready: got %0b want 0", o_load_ready); end
    step();
    step();
    n_checks++; if (o_load_ready !== 1'b0 || o_load_done !== 1'b1) begin n_errors++; $display("[TB] FAIL directed_hold: got r=%0b d=%0b want r=0 d=1", o_load_ready, o_load_done); end
  endtask

  task automatic test_fetch();
    fetch(32'd0);
    n_checks++; if (o_fetch_valid !== 1'b1 || o_instruction !== 32'h8C01_0004) begin n_errors++; $display("[TB] FAIL fetch_addr0: got v=%0b %h want v=1 8c010004", o_fetch_valid, o_instruction); end
    fetch(32'd4);
    n_checks++; if (o_fetch_valid !== 1'b1 || o_instruction !== HALT) begin n_errors++; $display("[TB] FAIL fetch_addr4: got v=%0b %h want v=1 ffffffff", o_fetch_valid, o_instruction); end
    fetch(32'd2);
    n_checks++; if (o_addr_misaligned !== 1'b1 || o_addr_out_of_range !== 1'b0 || o_fetch_valid !== 1'b0 || o_instruction !== 32'h0) begin n_errors++; $display("[TB] FAIL fetch_misaligned: got m=%0b r=%0b v=%0b %h want m=1 r=0 v=0 0", o_addr_misaligned, o_addr_out_of_range, o_fetch_valid, o_instruction); end
    fetch(32'd256);
    n_checks++; if (o_addr_out_of_range !== 1'b1 || o_addr_misaligned !== 1'b0 || o_fetch_valid !== 1'b0 || o_instruction !== 32'h0) begin n_errors++; $display("[TB] FAIL fetch_range: got m=%0b r=%0b v=%0b %h want m=0 r=1 v=0 0", o_addr_misaligned, o_addr_out_of_range, o_fetch_valid, o_instruction); end
    fetch(32'hFFFF_FFFC);
    n_checks++; if (o_addr_out_of_range !== 1'b1 || o_fetch_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL fetch_high_addr: got r=%0b v=%0b want r=1 v=0", o_addr_out_of_range, o_fetch_valid); end
    step();
    n_checks++; if (o_fetch_valid !== 1'b0 || o_instruction !== 32'h0 || o_addr_out_of_range !== 1'b0 || o_addr_misaligned !== 1'b0) begin n_errors++; $display("[TB] FAIL fetch_idle: got v=%0b %h r=%0b m=%0b want all 0", o_fetch_valid, o_instruction, o_addr_out_of_range, o_addr_misaligned); end
  endtask

  task automatic test_random_load();
    int ec; bit ed; int n;
    logic [31:0] a; logic [31:0] exp_i; bit mis, oor;
    prog_q = {};
    n = $urandom_range(2, 8);
    for (int k = 0; k < n; k++) push_word(rand_word());
    push_word(HALT);
    push_word(rand_word());
    model_load(ec, ed);
    load_program(1'b1);
    n_checks++; if (o_load_done !== ed || o_load_count !== 7'(ec)) begin n_errors++; $display("[TB] FAIL random_load: got d=%0b c=%0d want d=%0b c=%0d", o_load_done, o_load_count, ed, ec); end
    for (int k = 0; k < ec; k++) begin
      fetch(32'(4 * k));
      n_checks++; if (o_fetch_valid !== 1'b1 || o_instruction !== model_mem[k]) begin n_errors++; $display("[TB] FAIL random_word%0d: got v=%0b %h want v=1 %h", k, o_fetch_valid, o_instruction, model_mem[k]); end
    end
    for (int t = 0; t < 12; t++) begin
      a = 32'($urandom_range(0, 300));
      mis = (a % 4) != 0;
      oor = (a / 4) >= 64;
      exp_i = (mis || oor) ? 32'h0 : model_mem[a / 4];
      fetch(a);
      n_checks++; if (o_instruction !== exp_i || o_fetch_valid !== !(mis || oor) || o_addr_misaligned !== mis || o_addr_out_of_range !== oor) begin n_errors++; $display("[TB] FAIL random_fetch addr=%0d: got %h v=%0b m=%0b r=%0b want %h v=%0b m=%0b r=%0b", a, o_instruction, o_fetch_valid, o_addr_misaligned, o_addr_out_of_range, exp_i, !(mis || oor), mis, oor); end
    end
  endtask

  task automatic test_full_load();
    int ec; bit ed; int idx;
    prog_q = {};
    for (int k = 0; k < 64; k++) push_word(rand_word());
    prog_q.push_back(8'h5A);
    model_load(ec, ed);
    load_program(1'b1);
    n_checks++; if (o_load_done !== 1'b1 || o_load_count !== 7'd64) begin n_errors++; $display("[TB] FAIL full_done: got d=%0b c=%0d want d=1 c=64", o_load_done, o_load_count); end
    n_checks++; if (tx_q.size() != 1) begin n_errors++; $display("[TB] FAIL full_extra_byte: bytes left %0d want 1", tx_q.size()); end
    i_load_valid = 1'b1;
    i_load_byte  = 8'h5A;
    n_checks++; if (o_load_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL full_ready: got %0b want 0", o_load_ready); end
    step();
    i_load_valid = 1'b0;
    n_checks++; if (o_load_count !== 7'd64) begin n_errors++; $display("[TB] FAIL full_count_hold: got %0d want 64", o_load_count); end
    for (int t = 0; t < 6; t++) begin
      idx = (t == 0) ? 63 : $urandom_range(0, 63);
      fetch(32'(4 * idx));
      n_checks++; if (o_instruction !== model_mem[idx]) begin n_errors++; $display("[TB] FAIL full_word%0d: got %h want %h", idx, o_instruction, model_mem[idx]); end
    end
  endtask

  task automatic test_reset_mid_load();
    int ec; bit ed;
    logic [31:0] w1;
    prog_q = {};
    push_word(rand_word());
    w1 = rand_word();
    prog_q.push_back(w1[31:24]);
    prog_q.push_back(w1[23:16]);
    model_load(ec, ed);
    load_program(1'b0);
    i_reset_n = 1'b0;
    #1;
    n_checks++; if (o_load_ready !== 1'b0 || o_load_count !== 7'd0) begin n_errors++; $display("[TB] FAIL midreset_async: got r=%0b c=%0d want r=0 c=0", o_load_ready, o_load_count); end
    #2 i_reset_n = 1'b1;
    step();
    fetch(32'd0);
    n_checks++; if (o_instruction !== model_mem[0]) begin n_errors++; $display("[TB] FAIL midreset_word0: got %h want %h", o_instruction, model_mem[0]); end
    fetch(32'd4);
    n_checks++; if (o_instruction !== model_mem[1]) begin n_errors++; $display("[TB] FAIL midreset_word1: got %h want %h", o_instruction, model_mem[1]); end
    prog_q = {};
    push_word(rand_word());
    push_word(HALT);
    model_load(ec, ed);
    load_program(1'b1);
    fetch(32'd0);
    n_checks++; if (o_instruction !== model_mem[0] || o_load_count !== 7'(ec)) begin n_errors++; $display("[TB] FAIL midreset_reload: got %h c=%0d want %h c=%0d", o_instruction, o_load_count, model_mem[0], ec); end
  endtask

  task automatic test_enable_freeze();
    int ec; bit ed;
    prog_q = {};
    push_word(rand_word());
    push_word(HALT);
    model_load(ec, ed);
    tx_q = prog_q;
    start_load();
    for (int b = 0; b < 2; b++) begin
      i_load_valid = 1'b1;
      i_load_byte  = tx_q[0];
      step();
      void'(tx_q.pop_front());
    end
    i_enable     = 1'b0;
    i_load_byte  = 8'hA5;
    for (int c = 0; c < 5; c++) step();
    n_checks++; if (o_load_ready !== 1'b1 || o_load_count !== 7'd0) begin n_errors++; $display("[TB] FAIL freeze_hold: got r=%0b c=%0d want r=1 c=0", o_load_ready, o_load_count); end
    i_load_valid = 1'b0;
    i_enable     = 1'b1;
    stream(1'b1);
    n_checks++; if (o_load_done !== ed || o_load_count !== 7'(ec)) begin n_errors++; $display("[TB] FAIL freeze_resume: got d=%0b c=%0d want d=%0b c=%0d", o_load_done, o_load_count, ed, ec); end
    fetch(32'd0);
    n_checks++; if (o_instruction !== model_mem[0]) begin n_errors++; $display("[TB] FAIL freeze_word0: got %h want %h", o_instruction, model_mem[0]); end
  endtask

  task automatic test_fetch_blocked();
    int ec; bit ed;
    prog_q = {};
    push_word(HALT);
    model_load(ec, ed);
    tx_q = prog_q;
    start_load();
    fetch(32'd0);
    n_checks++; if (o_fetch_valid !== 1'b0 || o_instruction !== 32'h0 || o_addr_misaligned !== 1'b0) begin n_errors++; $display("[TB] FAIL blocked_fetch: got v=%0b %h m=%0b want v=0 0 m=0", o_fetch_valid, o_instruction, o_addr_misaligned); end
    stream(1'b0);
    fetch(32'd0);
    n_checks++; if (o_fetch_valid !== 1'b1 || o_instruction !== model_mem[0]) begin n_errors++; $display("[TB] FAIL blocked_after: got v=%0b %h want v=1 %h", o_fetch_valid, o_instruction, model_mem[0]); end
  endtask

  task automatic test_little_endian();
    logic [7:0] bytes [8];
    logic [31:0] exp_w;
    bytes = '{8'h04, 8'h00, 8'h01, 8'h8C, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_w = pack_word(bytes[0], bytes[1], bytes[2], bytes[3], 1'b0);
    le_load_start = 1'b1;
    step();
    le_load_start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!le_load_ready) break;
      le_load_valid = 1'b1;
      le_load_byte  = bytes[b];
      step();
    end
    le_load_valid = 1'b0;
    n_checks++; if (le_load_done !== 1'b1 || le_load_count !== 7'd2) begin n_errors++; $display("[TB] FAIL le_load: got d=%0b c=%0d want d=1 c=2", le_load_done, le_load_count); end
    le_fetch_en   = 1'b1;
    le_fetch_addr = 32'd0;
    step();
    le_fetch_en   = 1'b0;
    n_checks++; if (le_instruction !== exp_w || exp_w !== 32'h8C01_0004 || le_fetch_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL le_word0: got v=%0b %h want v=1 8c010004", le_fetch_valid, le_instruction); end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    for (int k = 0; k < 64; k++) model_mem[k] = 32'h0;
    i_reset_n     = 1'b0;
    i_enable      = 1'b1;
    i_load_start  = 1'b0;
    i_load_valid  = 1'b0;
    i_load_byte   = 8'h0;
    i_fetch_en    = 1'b0;
    i_fetch_addr  = 32'h0;
    le_load_start = 1'b0;
    le_load_valid = 1'b0;
    le_load_byte  = 8'h0;
    le_fetch_en   = 1'b0;
    le_fetch_addr = 32'h0;

    test_reset();
    test_directed_load();
    test_fetch();
    test_random_load();
    test_full_load();
    test_reset_mid_load();
    test_enable_freeze();
    test_fetch_blocked();
    test_little_endian();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
